// File: rtl/crl_host_seq_if.sv
// Command/response port and UART control-register bus of the host sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface crl_host_seq_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [3:0]  crl_order;
   logic        crl_wr;
   logic        crl_sw;
   logic [31:0] crl_wdata;
   logic [31:0] crl_rdata;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, crl_rdata,
      output cmd_ready, rsp_valid, rsp_data, rsp_err,
             crl_order, crl_wr, crl_sw, crl_wdata
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, crl_rdata,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err,
             crl_order, crl_wr, crl_sw, crl_wdata
   );
endinterface

// File: rtl/crl_host_seq.sv
// Sequences single commands onto the UART control-register bus; RX error reporting under CRL_HOST_RXERR_EN.
// Latency: 1 + accesses*(1+GAP_CYC) cycles from accept to rsp_valid, all outputs registered.
// Backpressure: cmd_ready is low from accept until the cycle after the response strobe.
module crl_host_seq #(
   parameter int POLL_MAX = 1023,
   parameter int GAP_CYC  = 2
) (
   input logic          clk,
   input logic          rst_n,
   crl_host_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ACC, GAP, POLL, PGAP, RESP} state_t;

   localparam logic [1:0]  OP_WR     = 2'd0;
   localparam logic [1:0]  OP_RD     = 2'd1;
   localparam logic [1:0]  OP_SEND   = 2'd2;
   localparam logic [1:0]  OP_RECV   = 2'd3;
   localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);
   localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

   state_t      state, state_nxt;
   logic [15:0] poll_cnt, poll_nxt, gap_cnt, gap_nxt;
   logic [1:0]  op_q, op_nxt, op_cur;
   logic [3:0]  addr_q, addr_nxt, addr_cur;
   logic [31:0] wdata_q, wdata_nxt, wdata_cur;
   logic        ready_q, ready_nxt;
   logic        cmd_ready_q, cmd_ready_nxt;
   logic        rsp_valid_q, rsp_valid_nxt;
   logic [31:0] rsp_data_q, rsp_data_nxt;
   logic        rsp_err_q, rsp_err_nxt;
   logic [3:0]  order_q, order_nxt;
   logic        wr_q, wr_nxt;
   logic        sw_q, sw_nxt;
   logic [31:0] crl_wdata_q, crl_wdata_nxt;
`ifdef CRL_HOST_RXERR_EN
   logic        rxerr_q, rxerr_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         poll_cnt    <= '0;
         gap_cnt     <= '0;
         op_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         order_q     <= '0;
         wr_q        <= 1'b0;
         sw_q        <= 1'b0;
         crl_wdata_q <= '0;
`ifdef CRL_HOST_RXERR_EN
         rxerr_q     <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         poll_cnt    <= poll_nxt;
         gap_cnt     <= gap_nxt;
         op_q        <= op_nxt;
         addr_q      <= addr_nxt;
         wdata_q     <= wdata_nxt;
         ready_q     <= ready_nxt;
         cmd_ready_q <= cmd_ready_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_data_q  <= rsp_data_nxt;
         rsp_err_q   <= rsp_err_nxt;
         order_q     <= order_nxt;
         wr_q        <= wr_nxt;
         sw_q        <= sw_nxt;
         crl_wdata_q <= crl_wdata_nxt;
`ifdef CRL_HOST_RXERR_EN
         rxerr_q     <= rxerr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      poll_nxt      = poll_cnt;
      gap_nxt       = gap_cnt;
      op_nxt        = op_q;
      addr_nxt      = addr_q;
      wdata_nxt     = wdata_q;
      ready_nxt     = ready_q;
      rsp_data_nxt  = rsp_data_q;
      rsp_err_nxt   = rsp_err_q;
      order_nxt     = order_q;
      wr_nxt        = wr_q;
      crl_wdata_nxt = crl_wdata_q;
      op_cur        = op_q;
      addr_cur      = addr_q;
      wdata_cur     = wdata_q;
`ifdef CRL_HOST_RXERR_EN
      rxerr_nxt     = rxerr_q;
`endif

      unique case (state)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               op_cur       = bus.cmd_op;
               addr_cur     = bus.cmd_addr;
               wdata_cur    = bus.cmd_wdata;
               op_nxt       = bus.cmd_op;
               addr_nxt     = bus.cmd_addr;
               wdata_nxt    = bus.cmd_wdata;
               poll_nxt     = '0;
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b0;
               state_nxt    = (bus.cmd_op == OP_SEND || bus.cmd_op == OP_RECV) ? POLL : ACC;
            end
         end
         POLL: begin
            // Only the bits that decide readiness (and RX errors) are kept from the STR sample.
            ready_nxt = (op_q == OP_SEND) ? !bus.crl_rdata[5] : bus.crl_rdata[0];
`ifdef CRL_HOST_RXERR_EN
            rxerr_nxt = bus.crl_rdata[1] | bus.crl_rdata[2];
`endif
            gap_nxt   = '0;
            state_nxt = PGAP;
         end
         PGAP: begin
            if (gap_cnt == GAP_LAST) begin
               if (ready_q) begin
                  state_nxt = ACC;
               end else if (poll_cnt == POLL_LAST) begin
                  rsp_err_nxt  = 1'b1;
                  rsp_data_nxt = '0;
                  state_nxt    = RESP;
               end else begin
                  poll_nxt  = poll_cnt + 16'd1;
                  state_nxt = POLL;
               end
            end else begin
               gap_nxt = gap_cnt + 16'd1;
            end
         end
         ACC: begin
            if (op_q == OP_RD) begin
               rsp_data_nxt = bus.crl_rdata;
            end else if (op_q == OP_RECV) begin
               rsp_data_nxt = {24'b0, bus.crl_rdata[7:0]};
`ifdef CRL_HOST_RXERR_EN
               rsp_err_nxt  = rxerr_q;
`endif
            end
            gap_nxt   = '0;
            state_nxt = GAP;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = RESP;
            else                     gap_nxt   = gap_cnt + 16'd1;
         end
         RESP: begin
            rsp_err_nxt = 1'b0;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Bus fields are loaded only when an access starts and then held through the gap.
      if (state_nxt == POLL) begin
         order_nxt = 4'd4;
         wr_nxt    = 1'b0;
      end else if (state_nxt == ACC) begin
         unique case (op_cur)
            OP_WR: begin
               order_nxt     = addr_cur;
               wr_nxt        = 1'b1;
               crl_wdata_nxt = wdata_cur;
            end
            OP_RD: begin
               order_nxt = addr_cur;
               wr_nxt    = 1'b0;
            end
            OP_SEND: begin
               order_nxt     = 4'd7;
               wr_nxt        = 1'b1;
               crl_wdata_nxt = {24'b0, wdata_cur[7:0]};
            end
            default: begin
               order_nxt = 4'd1;
               wr_nxt    = 1'b0;
            end
         endcase
      end

      cmd_ready_nxt = (state_nxt == IDLE);
      rsp_valid_nxt = (state_nxt == RESP);
      sw_nxt        = (state_nxt == POLL) || (state_nxt == ACC);
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.crl_order = order_q;
   assign bus.crl_wr    = wr_q;
   assign bus.crl_sw    = sw_q;
   assign bus.crl_wdata = crl_wdata_q;
endmodule

// File: tb/tb_crl_host_seq.sv
// Bench for crl_host_seq: directed vector table, reset abort sequence, randomized commands vs. a command-level model.
module tb_crl_host_seq;
   localparam int PM  = 4;
   localparam int GAP = 2;
`ifdef CRL_HOST_RXERR_EN
   localparam logic RXE = 1'b1;
`else
   localparam logic RXE = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   crl_host_seq_if bus();

   crl_host_seq #(.POLL_MAX(PM), .GAP_CYC(GAP)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   typedef struct packed {
      logic        wr;
      logic [3:0]  order;
      logic [31:0] wdata;
   } acc_t;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] str4;
      int          slen;
      logic [31:0] rdv;
      logic [31:0] e_data;
      logic        e_err;
      int          e_nacc;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  str_tab [16];
   int          str_len = 1;
   int          str_cnt = 0;
   int          str_base = 0;
   logic [31:0] rd_val = '0;
   acc_t        acc_log [$];
   acc_t        exp_q [$];
   logic        sw_prev = 1'b0;
   logic [31:0] m_data;
   logic        m_err;

   // Controller model: STR returns successive table entries (last one repeats), other orders return rd_val.
   always @(posedge clk)
      if (bus.crl_sw && bus.crl_order == 4'd4 && !bus.crl_wr) str_cnt <= str_cnt + 1;

   always_comb begin
      int idx;
      idx = str_cnt - str_base;
      if (idx >= str_len) idx = str_len - 1;
      if (idx < 0) idx = 0;
      bus.crl_rdata = rd_val;
      if (bus.crl_order == 4'd4) bus.crl_rdata = {24'b0, str_tab[idx[3:0]]};
   end

   always @(negedge clk) begin
      if (bus.crl_sw) begin
         acc_log.push_back({bus.crl_wr, bus.crl_order, bus.crl_wdata});
         checks++;
         if (sw_prev) begin
            errors++;
            $display("FAIL sw_back_to_back: crl_sw high two cycles in a row, required single-cycle pulse");
         end
      end
      sw_prev = bus.crl_sw;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
      end
   endtask

   // Command-level model: list of bus accesses plus the response.
   task automatic model(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] wdata);
      logic [7:0] s;
      logic       ok;
      exp_q.delete();
      m_data = '0;
      m_err  = 1'b0;
      if (op == 2'd0) begin
         exp_q.push_back({1'b1, addr, wdata});
      end else if (op == 2'd1) begin
         exp_q.push_back({1'b0, addr, 32'h0});
         m_data = (addr == 4'd4) ? {24'b0, str_tab[0]} : rd_val;
      end else begin
         ok = 1'b0;
         s  = '0;
         for (int p = 0; p < PM && !ok; p++) begin
            s = str_tab[(p < str_len) ? p : str_len - 1];
            exp_q.push_back({1'b0, 4'd4, 32'h0});
            ok = (op == 2'd2) ? !s[5] : s[0];
         end
         if (!ok) begin
            m_err = 1'b1;
         end else if (op == 2'd2) begin
            exp_q.push_back({1'b1, 4'd7, 24'b0, wdata[7:0]});
         end else begin
            exp_q.push_back({1'b0, 4'd1, 32'h0});
            m_data = {24'b0, rd_val[7:0]};
            if (RXE) m_err = s[1] | s[2];
         end
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [31:0] str4, input int slen, input logic [31:0] rdv,
                          output logic [31:0] g_data, output logic g_err, output int g_lat,
                          output int g_nacc);
      logic seen;
      for (int i = 0; i < 4; i++) str_tab[i] = str4[8*i +: 8];
      str_len = slen;
      rd_val  = rdv;
      model(op, addr, wdata);
      @(negedge clk);
      str_base = str_cnt;
      acc_log.delete();
      chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      @(posedge clk);
      #1;
      seen   = 1'b0;
      g_lat  = 0;
      g_data = '0;
      g_err  = 1'b0;
      for (int c = 1; c <= 400 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
         if (bus.rsp_valid) begin
            seen   = 1'b1;
            g_lat  = c;
            g_data = bus.rsp_data;
            g_err  = bus.rsp_err;
            bus.cmd_valid = 1'b0;
         end else begin
            // Commands offered while busy must be ignored.
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_op    = 2'($urandom);
            bus.cmd_addr  = 4'($urandom);
            bus.cmd_wdata = $urandom;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rsp_timeout: no rsp_valid within 400 cycles, required one response");
         bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
      chk("cmd_ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
      chk("rsp_err_cleared", 32'(bus.rsp_err), 32'd0);
      g_nacc = acc_log.size();
      chk("acc_count_vs_model", 32'(acc_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < acc_log.size() && i < exp_q.size(); i++) begin
         chk("acc_order", 32'(acc_log[i].order), 32'(exp_q[i].order));
         chk("acc_wr", 32'(acc_log[i].wr), 32'(exp_q[i].wr));
         if (exp_q[i].wr) chk("acc_wdata", acc_log[i].wdata, exp_q[i].wdata);
      end
   endtask

   initial begin
      vec_t        tbl [9];
      logic [31:0] g_data;
      logic        g_err;
      int          g_lat, g_nacc, rsp_cnt;

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      for (int i = 0; i < 16; i++) str_tab[i] = '0;

      //          op    addr   wdata          str bytes (b0 first) slen rdv           data           err   nacc
      tbl[0] = '{2'd0, 4'd3,  32'h0000_0023, 32'h0000_0000, 1, 32'h0,         32'h0,         1'b0, 1};
      tbl[1] = '{2'd1, 4'd5,  32'h0,         32'h0000_0000, 1, 32'h0000_01B2, 32'h0000_01B2, 1'b0, 1};
      tbl[2] = '{2'd2, 4'd0,  32'h0000_005A, 32'h0820_2020, 4, 32'h0,         32'h0,         1'b0, 5};
      tbl[3] = '{2'd3, 4'd0,  32'h0,         32'h0000_0008, 1, 32'h0,         32'h0,         1'b1, 4};
      tbl[4] = '{2'd3, 4'd0,  32'h0,         32'h0000_0005, 1, 32'h0000_00C3, 32'h0000_00C3, RXE,  2};
      tbl[5] = '{2'd0, 4'hE,  32'hDEAD_BEEF, 32'h0000_0000, 1, 32'h0,         32'h0,         1'b0, 1};
      tbl[6] = '{2'd2, 4'd0,  32'h0000_12A5, 32'h0000_0020, 1, 32'h0,         32'h0,         1'b1, 4};
      tbl[7] = '{2'd3, 4'd0,  32'h0,         32'h0000_0100, 2, 32'h0000_01FF, 32'h0000_00FF, 1'b0, 3};
      tbl[8] = '{2'd1, 4'd4,  32'h0,         32'h0000_003C, 1, 32'h1234_5678, 32'h0000_003C, 1'b0, 1};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'h0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_crl_sw", 32'(bus.crl_sw), 32'd0);
      chk("rst_crl_wr", 32'(bus.crl_wr), 32'd0);
      chk("rst_crl_order", 32'(bus.crl_order), 32'd0);
      chk("rst_crl_wdata", bus.crl_wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         run_cmd(tbl[v].op, tbl[v].addr, tbl[v].wdata, tbl[v].str4, tbl[v].slen, tbl[v].rdv,
                 g_data, g_err, g_lat, g_nacc);
         chk($sformatf("vec%0d_rsp_data", v), g_data, tbl[v].e_data);
         chk($sformatf("vec%0d_rsp_err", v), 32'(g_err), 32'(tbl[v].e_err));
         chk($sformatf("vec%0d_n_access", v), 32'(g_nacc), 32'(tbl[v].e_nacc));
         chk($sformatf("vec%0d_latency", v), 32'(g_lat), 32'(1 + tbl[v].e_nacc * (1 + GAP)));
      end

      // Reset during the post-poll gap of a SEND that would never become ready.
      str_tab[0] = 8'h20;
      str_len    = 1;
      @(negedge clk);
      str_base      = str_cnt;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd2;
      bus.cmd_addr  = 4'd0;
      bus.cmd_wdata = 32'h11;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("abort_poll_strobe", 32'(bus.crl_sw), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_crl_sw", 32'(bus.crl_sw), 32'd0);
      chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort_crl_order", 32'(bus.crl_order), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      acc_log.delete();
      rsp_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rsp_valid) rsp_cnt++;
      end
      chk("abort_no_rsp", 32'(rsp_cnt), 32'd0);
      chk("abort_no_access", 32'(acc_log.size()), 32'd0);
      chk("abort_idle_ready", 32'(bus.cmd_ready), 32'd1);

      for (int n = 0; n < 40; n++) begin
         logic [1:0]  op;
         logic [3:0]  addr;
         logic [31:0] wd, s4, rv;
         int          sl;
         op   = 2'($urandom_range(0, 3));
         addr = 4'($urandom);
         wd   = $urandom;
         s4   = $urandom;
         rv   = $urandom;
         sl   = $urandom_range(1, 4);
         run_cmd(op, addr, wd, s4, sl, rv, g_data, g_err, g_lat, g_nacc);
         chk("rnd_rsp_data", g_data, m_data);
         chk("rnd_rsp_err", 32'(g_err), 32'(m_err));
         chk("rnd_latency", 32'(g_lat), 32'(1 + exp_q.size() * (1 + GAP)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/crl_host_seq.md
Name: crl_host_seq

Overview:
Initiator-side sequencer that drives the UART control register interface (crl_order, crl_wr, crl_sw, crl_wdata, crl_rdata) on behalf of an upstream command source.
- It accepts single commands over a valid/ready handshake: register write, register read, send byte, or receive byte.
- For send byte and receive byte it polls the status register (STR) until the FIFO condition allows the access.
- It returns one response per command.
- It sits between a host/CPU-side command port and the UART control block.

Parameters:
- POLL_MAX, 1023, maximum STR polls per send/receive command before timeout. Range 1..65535.
- GAP_CYC, 2, idle cycles with crl_sw=0 inserted after every bus access. Minimum 1, so that registered push/pop and status updates settle.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  0=REG_WR, 1=REG_RD, 2=SEND, 3=RECV
- cmd_addr  in  4  register order code, used by REG_WR/REG_RD (1=RB, 2=IER, 3=CTR, 4=STR, 5=DL, 6=DBG, 7=TB)
- cmd_wdata  in  32  write data; SEND uses [7:0]
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  32  read data (REG_RD, RECV zero-extended); 0 for writes
- rsp_err  out  1  command failed (timeout, or feature error)
- crl_order  out  4  order code to the controller
- crl_wr  out  1  1=write, 0=read; meaningful only while crl_sw=1
- crl_sw  out  1  access strobe, exactly one cycle per access
- crl_wdata  out  32  write data to the controller
- crl_rdata  in  32  combinational read data from the controller, valid in the crl_sw cycle

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
  - crl_sw=0, crl_wr=0, crl_order=0, crl_wdata=0.
  - FSM=IDLE, poll counter=0, gap counter=0.
- All outputs are registered.
- Reset asserted mid-command aborts it immediately: no response is issued and the bus returns to idle.

FSM states: IDLE, ACC, GAP, POLL, PGAP, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch op, addr and wdata; clear the poll counter; cmd_ready goes 0 the next cycle.
  - REG_WR/REG_RD go to ACC.
  - SEND/RECV go to POLL.
- POLL
  - One cycle with crl_sw=1, crl_wr=0, crl_order=4 (STR).
  - Sample crl_rdata[7:0] in the same cycle, then go to PGAP.
- PGAP
  - GAP_CYC cycles with crl_sw=0.
  - Ready condition: SEND is ready when sampled STR[5] (tf_full)=0; RECV is ready when sampled STR[0] (rx has data)=1.
  - If ready: go to ACC.
  - Else if poll count reached POLL_MAX: set rsp_err=1, rsp_data=0, go to RESP.
  - Else increment the poll count and go to POLL.
- ACC
  - One cycle with crl_sw=1.
  - REG_WR: crl_wr=1, order=addr, wdata=latched.
  - REG_RD: crl_wr=0, order=addr.
  - SEND: crl_wr=1, order=7, crl_wdata={24'b0, byte}.
  - RECV: crl_wr=0, order=1.
  - Reads capture crl_rdata into rsp_data in this cycle (RECV: {24'b0, crl_rdata[7:0]}).
  - Go to GAP.
- GAP
  - GAP_CYC cycles with crl_sw=0, then RESP.
- RESP
  - rsp_valid=1 for exactly one cycle, with rsp_data and rsp_err stable during it.
  - Next cycle: IDLE, cmd_ready=1, rsp_valid=0, rsp_err cleared.

Bus rules:
- crl_sw never stays high two consecutive cycles.
- crl_order and crl_wdata hold their value through the gap cycles; only crl_sw drops.

Boundaries:
- POLL_MAX=1: the command times out after one failed poll.
- An unknown cmd_addr is passed through unchanged; it is the controller's to ignore.
- A DL write does not force CTR[5]; upstream must write CTR first.
- One command is outstanding at a time; cmd_valid while cmd_ready=0 is ignored.

Optional Feature:
CRL_HOST_RXERR_EN
- Defined: on RECV, the STR sample that satisfied the ready condition is checked for STR[1] (overrun) or STR[2] (parity error). If either is set, the RB read still completes and returns its data, but rsp_err=1.
- Undefined: rsp_err reflects timeout only, and status error bits are ignored.

Test Plan:
- Reset mid-command: assert rst_n=0 during the PGAP of a SEND. Required: no response, crl_sw=0, cmd_ready=1 after release, FSM=IDLE.
- REG_WR addr=3 wdata=0x23.
  - Required: exactly one crl_sw pulse with crl_wr=1, order=3, wdata=0x23.
  - Then GAP_CYC idle cycles.
  - Then rsp_valid with rsp_data=0, rsp_err=0.
  - cmd_ready returns 1 one cycle after rsp_valid.
- REG_RD addr=5, with the controller returning 0x0000_01B2. Required: rsp_data=0x0000_01B2, rsp_err=0, and the crl_sw pulse has crl_wr=0.
- SEND 0x5A with STR returning 0x20 for 3 polls, then 0x08.
  - Required: 4 STR reads, each followed by 2 idle cycles.
  - Then one TB write with wdata=0x0000_005A.
  - Then rsp_err=0.
- RECV with STR stuck at 0x08, POLL_MAX=4. Required: exactly 4 STR polls, no RB read, rsp_valid with rsp_err=1 and rsp_data=0.
- RECV with STR=0x05 and RB=0xC3.
  - Required: rsp_data=0x0000_00C3.
  - rsp_err=1 with CRL_HOST_RXERR_EN defined; rsp_err=0 without it.
